// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic; imported by next_pc_sel and fetch_unit.
// No flow control of its own.
package fetch_pkg;

    typedef enum logic [1:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR} pc_src_e;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} fetch_state_e;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    localparam int JMP_J_BIT    = 0;
    localparam int JMP_JR_BIT   = 1;
    localparam int JMP_LINK_BIT = 2;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/next_pc_sel.sv
// Resolves decode branch/jump controls into a PC source and a target address.
// Purely combinational, zero latency.
// No flow control; the caller decides whether the redirect is accepted.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [1:0]  branch,
    input  logic        equal,
    input  logic [2:0]  jump,
    input  logic [31:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] jr_target,
    input  logic [31:0] pc_plus4,
    output pc_src_e     pc_src,
    output logic [31:0] target
);

    // The link bit only matters to writeback, not to where fetch goes next.
    logic unused_link;
    assign unused_link = jump[JMP_LINK_BIT];

    always_comb begin
        pc_src = PC_SEQ;
        if (jump[JMP_JR_BIT]) begin
            pc_src = PC_JR;
        end else if (jump[JMP_J_BIT]) begin
            pc_src = PC_JUMP;
        end else if (branch != BR_NONE) begin
            if ((branch == BR_EQ && equal) || (branch == BR_NE && !equal)) begin
                pc_src = PC_BRANCH;
            end
        end
    end

    always_comb begin
        case (pc_src)
            PC_JR:   target = jr_target;
            PC_JUMP: target = {pc_plus4[31:28], jaddr, 2'b00};
            default: target = pc_plus4 + {imm[29:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory request and IF/ID pipeline register.
// Latency: address in cycle N returns on instr_o in N+1; a redirect costs one bubble.
// Backpressure: stall_i freezes PC and IF/ID; imem_ready_i=0 holds PC and inserts bubbles.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic [1:0]  branch_i,
    input  logic        equal_i,
    input  logic [2:0]  jump_i,
    input  logic [31:0] imm_i,
    input  logic [25:0] jaddr_i,
    input  logic [31:0] jr_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        redirect_o,
    output logic        halt_o
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  ifid_instr, ifid_pc4;
    logic         ifid_vld;
    pc_src_e      pc_src;
    logic [31:0]  target;
    logic         redirect, misaligned;

    next_pc_sel u_next_pc_sel (
        .branch    (branch_i),
        .equal     (equal_i),
        .jump      (jump_i),
        .imm       (imm_i),
        .jaddr     (jaddr_i),
        .jr_target (jr_target_i),
        .pc_plus4  (ifid_pc4),
        .pc_src    (pc_src),
        .target    (target)
    );

    // Decode only owns a real instruction when IF/ID is valid; a stalled redirect is re-presented later.
    assign redirect   = (pc_src != PC_SEQ) && ifid_vld && !stall_i && (state == S_RUN);
    assign misaligned = (target[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   if (redirect && misaligned) state_nxt = S_HALT;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (state == S_RUN) begin
            if (redirect) begin
                if (!misaligned) pc_nxt = target;
            end else if (!stall_i && imem_ready_i) begin
                pc_nxt = pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'h0;
            ifid_vld   <= 1'b0;
        end else if (redirect || state != S_RUN) begin
            ifid_instr <= NOP_INSTR;
            ifid_vld   <= 1'b0;
        end else if (stall_i) begin
            ifid_instr <= ifid_instr;
            ifid_vld   <= ifid_vld;
        end else if (imem_ready_i) begin
            ifid_instr <= imem_rdata_i;
            ifid_pc4   <= pc + 32'd4;
            ifid_vld   <= 1'b1;
        end else begin
            ifid_instr <= NOP_INSTR;
            ifid_vld   <= 1'b0;
        end
    end

    assign imem_req_o  = (state == S_RUN);
    assign imem_addr_o = pc;
    assign instr_o     = ifid_instr;
    assign pc_plus4_o  = ifid_pc4;
    assign valid_o     = ifid_vld;
    assign redirect_o  = redirect;
    assign halt_o      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a cycle-level behavioural model of the fetch rules,
// preceded by short directed scenarios for branch, jump, stall, wrap and halt cases.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic [1:0]  branch_i;
    logic        equal_i;
    logic [2:0]  jump_i;
    logic [31:0] imm_i;
    logic [25:0] jaddr_i;
    logic [31:0] jr_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        redirect_o;
    logic        halt_o;

    int checks = 0;
    int errors = 0;

    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int          m_st;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .equal_i      (equal_i),
        .jump_i       (jump_i),
        .imm_i        (imm_i),
        .jaddr_i      (jaddr_i),
        .jr_target_i  (jr_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .imem_ready_i (imem_ready_i),
        .instr_o      (instr_o),
        .pc_plus4_o   (pc_plus4_o),
        .valid_o      (valid_o),
        .redirect_o   (redirect_o),
        .halt_o       (halt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    function automatic logic m_taken(input logic [1:0] br, input logic eq, input logic [2:0] jmp);
        return (br == 2'b01 && eq) || (br == 2'b10 && !eq) || (jmp[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_target(input logic [2:0] jmp, input logic [31:0] imm,
                                             input logic [25:0] ja, input logic [31:0] jrt);
        if (jmp[1]) return jrt;
        if (jmp[0]) return {m_pc4[31:28], ja, 2'b00};
        return m_pc4 + imm * 4;
    endfunction

    task automatic step(input logic st, input logic [1:0] br, input logic eq, input logic [2:0] jmp,
                        input logic [31:0] imm, input logic [25:0] ja, input logic [31:0] jrt,
                        input logic rdy);
        logic        redir;
        logic [31:0] tgt, rdata;
        @(negedge clk_i);
        rdata        = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;
        stall_i      = st;
        branch_i     = br;
        equal_i      = eq;
        jump_i       = jmp;
        imm_i        = imm;
        jaddr_i      = ja;
        jr_target_i  = jrt;
        imem_ready_i = rdy;
        imem_rdata_i = rdata;
        #1;
        tgt   = m_target(jmp, imm, ja, jrt);
        redir = m_taken(br, eq, jmp) && m_valid && !st && (m_st == M_RUN);
        check("addr", imem_addr_o, m_pc);
        check("req", {31'b0, imem_req_o}, {31'b0, m_st == M_RUN});
        check("instr", instr_o, m_instr);
        check("pc4", pc_plus4_o, m_pc4);
        check("valid", {31'b0, valid_o}, {31'b0, m_valid});
        check("redirect", {31'b0, redirect_o}, {31'b0, redir});
        check("halt", {31'b0, halt_o}, {31'b0, m_st == M_HALT});
        if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            if (redir) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                if (tgt % 4 != 0) m_st = M_HALT;
                else m_pc = tgt;
            end else if (!st) begin
                if (rdy) begin
                    m_instr = rdata;
                    m_pc4   = m_pc + 4;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 4;
                end else begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end
            end
        end
        @(posedge clk_i);
    endtask

    task automatic plain(input logic rdy);
        step(1'b0, 2'b00, 1'b0, 3'b000, 32'h0, 26'h0, 32'h0, rdy);
    endtask

    task automatic reset_pulse();
        @(negedge clk_i);
        rst_ni = 1'b0;
        stall_i = 1'b0; branch_i = 2'b00; equal_i = 1'b0; jump_i = 3'b000;
        imem_ready_i = 1'b0;
        #1;
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc4", pc_plus4_o, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_halt", {31'b0, halt_o}, 32'h0);
        m_st = M_BOOT; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic rand_step();
        logic [31:0] r, jrt;
        logic [2:0]  jmp;
        r   = $urandom;
        jrt = $urandom;
        jrt[1:0] = 2'b00;
        if ($urandom_range(0, 39) == 0) jrt[1:0] = 2'($urandom_range(1, 3));
        else if ($urandom_range(0, 9) == 0) jrt[31:4] = 28'hFFF_FFFF;
        jmp = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        step($urandom_range(0, 4) == 0, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), jmp,
             {{20{r[11]}}, r[11:0]}, 26'($urandom), jrt, $urandom_range(0, 5) != 0);
    endtask

    initial begin
        rst_ni = 1'b0; stall_i = 1'b0; branch_i = 2'b00; equal_i = 1'b0; jump_i = 3'b000;
        imm_i = 32'h0; jaddr_i = 26'h0; jr_target_i = 32'h0;
        imem_ready_i = 1'b0; imem_rdata_i = 32'h0;
        reset_pulse();

        // Sequential fetch until the instruction at 0x10 sits in IF/ID, then a backward BEQ.
        for (int k = 0; k < 20 && !(m_valid && m_pc4 == 32'h14); k++) plain(1'b1);
        step(1'b0, 2'b01, 1'b1, 3'b000, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b1);
        #1;
        check("beq_addr", imem_addr_o, 32'h0000_000C);
        check("beq_bubble", {31'b0, valid_o}, 32'h0);

        plain(1'b1);
        step(1'b0, 2'b10, 1'b1, 3'b000, 32'h10, 26'h0, 32'h0, 1'b1);
        step(1'b0, 2'b01, 1'b1, 3'b010, 32'h10, 26'h0, 32'h40, 1'b1);
        #1 check("jr_prio_addr", imem_addr_o, 32'h0000_0040);

        plain(1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 1'b0, 3'b001, 32'h0, 26'h123, 32'h0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 3'b001, 32'h0, 26'h123, 32'h0, 1'b1);
        #1 check("j_after_stall", imem_addr_o, 32'h0000_048C);

        plain(1'b0);
        plain(1'b0);

        plain(1'b1);
        step(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b1);
        plain(1'b1);
        #1;
        check("wrap_addr", imem_addr_o, 32'h0);
        check("wrap_pc4", pc_plus4_o, 32'h0);

        plain(1'b1);
        step(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 26'h0, 32'h42, 1'b1);
        #1;
        check("mis_halt", {31'b0, halt_o}, 32'h1);
        check("mis_req", {31'b0, imem_req_o}, 32'h0);
        for (int k = 0; k < 3; k++) plain(1'b1);
        reset_pulse();

        for (int i = 0; i < 3000; i++) begin
            if ((m_st == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0)
                reset_pulse();
            else
                rand_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
